// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester (fetch/data/vector) handshake and memory macro bus; slave = arbiter side, master = requesters plus memory
interface mem_port_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          f_req;
  logic          f_lock;
  logic [AW-1:0] f_addr;
  logic          f_gnt;
  logic          f_rvalid;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic          v_req;
  logic          v_sel;
  logic          v_gnt;
  logic          v_rvalid;
  logic [DW-1:0] rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          stall_fetch;
  logic          busy;
  modport slave (
    input  f_req, f_lock, f_addr, d_req, d_we, d_addr, d_wdata, v_req, v_sel, mem_rdata,
    output f_gnt, f_rvalid, d_gnt, d_rvalid, v_gnt, v_rvalid, rdata,
           mem_en, mem_we, mem_addr, mem_wdata, stall_fetch, busy
  );
  modport master (
    output f_req, f_lock, f_addr, d_req, d_we, d_addr, d_wdata, v_req, v_sel, mem_rdata,
    input  f_gnt, f_rvalid, d_gnt, d_rvalid, v_gnt, v_rvalid, rdata,
           mem_en, mem_we, mem_addr, mem_wdata, stall_fetch, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: single-port memory arbiter (vector > data > fetch, fetch lock slot, anti-starvation, read return routing); ports clk, rst, bus (slave)
module mem_port_arbiter #(
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int STARVE = 4
) (
  input logic            clk,
  input logic            rst,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic {IDLE, LOCK} state_t;
  typedef enum logic [1:0] {O_NONE, O_F, O_D, O_V} owner_t;
  state_t     state, state_nx;
  owner_t     owner, owner_nx;
  logic [3:0] fwait, fwait_nx;
  logic       lock_slot, promo, f_gnt, d_gnt, v_gnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= O_NONE;
      fwait <= '0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      fwait <= fwait_nx;
    end
  end
  always_comb begin
    lock_slot = state == LOCK && bus.f_req;
    promo     = fwait >= 4'(STARVE);
    v_gnt     = !rst && !lock_slot && bus.v_req;
    f_gnt     = !rst && (lock_slot || (!bus.v_req && bus.f_req && (promo || !bus.d_req)));
    d_gnt     = !rst && !lock_slot && !bus.v_req && bus.d_req && !(promo && bus.f_req);
    state_nx  = (state == IDLE && f_gnt && bus.f_lock) ? LOCK : IDLE;
    owner_nx  = v_gnt ? O_V : (d_gnt && !bus.d_we) ? O_D : f_gnt ? O_F : O_NONE;
    fwait_nx  = (f_gnt || !bus.f_req) ? 4'd0 : (fwait == 4'hf) ? fwait : fwait + 4'd1;
  end
  assign bus.f_gnt       = f_gnt;
  assign bus.d_gnt       = d_gnt;
  assign bus.v_gnt       = v_gnt;
  assign bus.mem_en      = f_gnt || d_gnt || v_gnt;
  assign bus.mem_we      = d_gnt && bus.d_we;
  assign bus.mem_addr    = f_gnt ? bus.f_addr : d_gnt ? bus.d_addr : v_gnt ? {{(AW-1){1'b0}}, bus.v_sel} : '0;
  assign bus.mem_wdata   = d_gnt ? bus.d_wdata : {DW{1'b0}};
  assign bus.f_rvalid    = !rst && owner == O_F;
  assign bus.d_rvalid    = !rst && owner == O_D;
  assign bus.v_rvalid    = !rst && owner == O_V;
  assign bus.rdata       = rst ? {DW{1'b0}} : bus.mem_rdata;
  assign bus.stall_fetch = !rst && bus.f_req && !f_gnt;
  assign bus.busy        = !rst && (state == LOCK || owner != O_NONE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized model-checked bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int STARVE = 4;
  logic clk = 0;
  logic rst = 1;
  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] ref_mem [256];
  logic [7:0] mem [256];
  logic [7:0] mem_q = 8'd0;
  logic mem_ready = 0;
  mem_port_arbiter_if #(.AW(8), .DW(8)) bus ();
  mem_port_arbiter #(.AW(8), .DW(8), .STARVE(STARVE)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.mem_rdata = mem_q;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 37 + 11);
      mem_ready <= 1;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else mem_q <= mem[bus.mem_addr];
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clear;
    bus.f_req = 0; bus.f_lock = 0; bus.f_addr = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
    bus.v_req = 0; bus.v_sel = 0;
  endtask
  task automatic do_reset;
    clear();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask
  task automatic test_reset;
    logic [9:0] o;
    do_reset();
    #1;
    o = {bus.f_gnt, bus.d_gnt, bus.v_gnt, bus.f_rvalid, bus.d_rvalid, bus.v_rvalid, bus.mem_en, bus.mem_we, bus.busy, bus.stall_fetch};
    n_tests++; if (o !== 10'd0 || bus.mem_addr !== 8'd0) begin n_fail++; $display("FAIL reset_idle got %b addr %h want 0", o, bus.mem_addr); end
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 8'h33;
    #1;
    n_tests++; if (bus.d_gnt !== 1'b1) begin n_fail++; $display("FAIL reset_pre_dgnt got %b want 1", bus.d_gnt); end
    tick();
    rst = 1;
    bus.f_req = 1; bus.v_req = 1;
    #1;
    o = {bus.f_gnt, bus.d_gnt, bus.v_gnt, bus.f_rvalid, bus.d_rvalid, bus.v_rvalid, bus.mem_en, bus.mem_we, bus.busy, bus.stall_fetch};
    n_tests++; if (o !== 10'd0) begin n_fail++; $display("FAIL reset_in_rst got %b want 0", o); end
    tick();
    rst = 0;
    clear();
    #1;
    o = {bus.f_gnt, bus.d_gnt, bus.v_gnt, bus.f_rvalid, bus.d_rvalid, bus.v_rvalid, bus.mem_en, bus.mem_we, bus.busy, bus.stall_fetch};
    n_tests++; if (o !== 10'd0) begin n_fail++; $display("FAIL reset_after got %b want 0", o); end
  endtask
  task automatic test_priority;
    do_reset();
    bus.f_req = 1; bus.f_addr = 8'h20;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 8'h40;
    bus.v_req = 1; bus.v_sel = 1;
    #1;
    n_tests++; if ({bus.f_gnt, bus.d_gnt, bus.v_gnt} !== 3'b001 || bus.mem_addr !== 8'h01) begin n_fail++; $display("FAIL prio_v gnt %b addr %h want 001 01", {bus.f_gnt, bus.d_gnt, bus.v_gnt}, bus.mem_addr); end
    tick();
    bus.v_req = 0;
    #1;
    n_tests++; if ({bus.f_gnt, bus.d_gnt, bus.v_gnt} !== 3'b010 || bus.mem_addr !== 8'h40) begin n_fail++; $display("FAIL prio_d gnt %b addr %h want 010 40", {bus.f_gnt, bus.d_gnt, bus.v_gnt}, bus.mem_addr); end
    n_tests++; if (bus.v_rvalid !== 1'b1 || bus.rdata !== ref_mem[1]) begin n_fail++; $display("FAIL prio_vret rv %b data %h want 1 %h", bus.v_rvalid, bus.rdata, ref_mem[1]); end
    tick();
    bus.d_req = 0;
    #1;
    n_tests++; if ({bus.f_gnt, bus.d_gnt, bus.v_gnt} !== 3'b100 || bus.mem_addr !== 8'h20) begin n_fail++; $display("FAIL prio_f gnt %b addr %h want 100 20", {bus.f_gnt, bus.d_gnt, bus.v_gnt}, bus.mem_addr); end
    n_tests++; if (bus.d_rvalid !== 1'b1 || bus.rdata !== ref_mem[8'h40]) begin n_fail++; $display("FAIL prio_dret rv %b data %h want 1 %h", bus.d_rvalid, bus.rdata, ref_mem[8'h40]); end
    tick();
    clear();
    #1;
    n_tests++; if ({bus.f_rvalid, bus.d_rvalid, bus.v_rvalid} !== 3'b100 || bus.rdata !== ref_mem[8'h20]) begin n_fail++; $display("FAIL prio_fret rv %b data %h want 100 %h", {bus.f_rvalid, bus.d_rvalid, bus.v_rvalid}, bus.rdata, ref_mem[8'h20]); end
  endtask
  task automatic test_lock;
    do_reset();
    bus.f_req = 1; bus.f_lock = 1; bus.f_addr = 8'h10;
    #1;
    n_tests++; if (bus.f_gnt !== 1'b1) begin n_fail++; $display("FAIL lock_first got %b want 1", bus.f_gnt); end
    tick();
    bus.f_addr = 8'h11;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 8'h30;
    #1;
    n_tests++; if ({bus.f_gnt, bus.d_gnt} !== 2'b10 || bus.mem_addr !== 8'h11 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL lock_second gnt %b addr %h busy %b want 10 11 1", {bus.f_gnt, bus.d_gnt}, bus.mem_addr, bus.busy); end
    tick();
    bus.f_addr = 8'h12; bus.f_lock = 0;
    #1;
    n_tests++; if ({bus.f_gnt, bus.d_gnt} !== 2'b01 || bus.stall_fetch !== 1'b1) begin n_fail++; $display("FAIL lock_no_reenter gnt %b stall %b want 01 1", {bus.f_gnt, bus.d_gnt}, bus.stall_fetch); end
    n_tests++; if (bus.f_rvalid !== 1'b1 || bus.rdata !== ref_mem[8'h11]) begin n_fail++; $display("FAIL lock_fret rv %b data %h want 1 %h", bus.f_rvalid, bus.rdata, ref_mem[8'h11]); end
    tick();
    clear();
  endtask
  task automatic test_lock_abandon;
    do_reset();
    bus.f_req = 1; bus.f_lock = 1; bus.f_addr = 8'h50;
    #1;
    n_tests++; if (bus.f_gnt !== 1'b1) begin n_fail++; $display("FAIL abandon_first got %b want 1", bus.f_gnt); end
    tick();
    clear();
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 8'h55;
    #1;
    n_tests++; if ({bus.f_gnt, bus.d_gnt, bus.v_gnt} !== 3'b010 || bus.mem_addr !== 8'h55 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL abandon_d gnt %b addr %h busy %b want 010 55 1", {bus.f_gnt, bus.d_gnt, bus.v_gnt}, bus.mem_addr, bus.busy); end
    tick();
    clear();
    #1;
    n_tests++; if (bus.d_rvalid !== 1'b1 || bus.rdata !== ref_mem[8'h55]) begin n_fail++; $display("FAIL abandon_dret rv %b data %h want 1 %h", bus.d_rvalid, bus.rdata, ref_mem[8'h55]); end
    tick();
    #1;
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abandon_idle busy %b want 0", bus.busy); end
  endtask
  task automatic test_lock_vector;
    do_reset();
    bus.f_req = 1; bus.f_lock = 1; bus.f_addr = 8'h20;
    #1;
    tick();
    bus.f_addr = 8'h21; bus.f_lock = 0;
    bus.v_req = 1; bus.v_sel = 0;
    #1;
    n_tests++; if ({bus.f_gnt, bus.d_gnt, bus.v_gnt} !== 3'b100 || bus.mem_addr !== 8'h21) begin n_fail++; $display("FAIL lockvec_f gnt %b addr %h want 100 21", {bus.f_gnt, bus.d_gnt, bus.v_gnt}, bus.mem_addr); end
    tick();
    bus.f_req = 0;
    #1;
    n_tests++; if ({bus.f_gnt, bus.d_gnt, bus.v_gnt} !== 3'b001 || bus.mem_addr !== 8'h00) begin n_fail++; $display("FAIL lockvec_v gnt %b addr %h want 001 00", {bus.f_gnt, bus.d_gnt, bus.v_gnt}, bus.mem_addr); end
    tick();
    clear();
  endtask
  task automatic test_starvation;
    int k = 0;
    bit ef;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      bus.f_req = 1; bus.f_lock = 0; bus.f_addr = 8'h60;
      bus.d_req = 1; bus.d_we = 1; bus.d_addr = 8'(8'h80 + k); bus.d_wdata = 8'(k * 3 + 1);
      #1;
      ef = (i % (STARVE + 1)) == STARVE;
      n_tests++; if ({bus.f_gnt, bus.d_gnt} !== {ef, !ef} || bus.stall_fetch !== !ef) begin n_fail++; $display("FAIL starve_c%0d gnt %b stall %b want %b%b %b", i, {bus.f_gnt, bus.d_gnt}, bus.stall_fetch, ef, !ef, !ef); end
      if (!ef) begin
        ref_mem[8'(8'h80 + k)] = 8'(k * 3 + 1);
        k++;
      end
      tick();
    end
    clear();
  endtask
  task automatic test_write;
    do_reset();
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 8'hFE; bus.d_wdata = 8'hA5;
    #1;
    n_tests++; if ({bus.d_gnt, bus.mem_en, bus.mem_we} !== 3'b111 || bus.mem_addr !== 8'hFE || bus.mem_wdata !== 8'hA5) begin n_fail++; $display("FAIL write_bus ctl %b addr %h data %h want 111 fe a5", {bus.d_gnt, bus.mem_en, bus.mem_we}, bus.mem_addr, bus.mem_wdata); end
    ref_mem[8'hFE] = 8'hA5;
    tick();
    clear();
    #1;
    n_tests++; if ({bus.f_rvalid, bus.d_rvalid, bus.v_rvalid, bus.busy} !== 4'b0000) begin n_fail++; $display("FAIL write_norv got %b want 0000", {bus.f_rvalid, bus.d_rvalid, bus.v_rvalid, bus.busy}); end
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 8'hFE;
    tick();
    clear();
    #1;
    n_tests++; if (bus.d_rvalid !== 1'b1 || bus.rdata !== 8'hA5) begin n_fail++; $display("FAIL write_readback rv %b data %h want 1 a5", bus.d_rvalid, bus.rdata); end
  endtask
  task automatic test_random;
    bit pf = 0, pd = 0, pv = 0, fl = 0, dw = 0, vs = 0, lk = 0;
    logic [7:0] fa = 0, da = 0, dd = 0, ea, ewd, rd = 0;
    int w = 0, own = 0, g;
    bit ewe;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (!pf && $urandom_range(1, 0) == 1) begin pf = 1; fa = 8'($urandom); fl = $urandom_range(2, 0) == 0; end
      if (!pd && $urandom_range(1, 0) == 1) begin pd = 1; da = 8'($urandom); dd = 8'($urandom); dw = $urandom_range(1, 0) == 1; end
      if (!pv && $urandom_range(5, 0) == 0) begin pv = 1; vs = $urandom_range(1, 0) == 1; end
      bus.f_req = pf; bus.f_lock = fl; bus.f_addr = fa;
      bus.d_req = pd; bus.d_we = dw; bus.d_addr = da; bus.d_wdata = dd;
      bus.v_req = pv; bus.v_sel = vs;
      #1;
      n_tests++; if ({bus.f_rvalid, bus.d_rvalid, bus.v_rvalid} !== {own == 1, own == 2, own == 3}) begin n_fail++; $display("FAIL rnd_rvalid c%0d got %b want owner %0d", c, {bus.f_rvalid, bus.d_rvalid, bus.v_rvalid}, own); end
      if (own != 0) begin
        n_tests++; if (bus.rdata !== rd) begin n_fail++; $display("FAIL rnd_rdata c%0d got %h want %h", c, bus.rdata, rd); end
      end
      n_tests++; if (bus.busy !== (lk || own != 0)) begin n_fail++; $display("FAIL rnd_busy c%0d got %b want %b", c, bus.busy, lk || own != 0); end
      if (lk && pf) g = 1;
      else if (pv) g = 3;
      else if (pf && (w >= STARVE || !pd)) g = 1;
      else if (pd) g = 2;
      else g = 0;
      ea = g == 1 ? fa : g == 2 ? da : g == 3 ? {7'd0, vs} : 8'd0;
      ewe = g == 2 && dw;
      ewd = g == 2 ? dd : 8'd0;
      n_tests++; if ({bus.f_gnt, bus.d_gnt, bus.v_gnt} !== {g == 1, g == 2, g == 3}) begin n_fail++; $display("FAIL rnd_gnt c%0d got %b want requester %0d", c, {bus.f_gnt, bus.d_gnt, bus.v_gnt}, g); end
      n_tests++; if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {g != 0, ewe, ea, ewd}) begin n_fail++; $display("FAIL rnd_mem c%0d got %b %b %h %h want %b %b %h %h", c, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, g != 0, ewe, ea, ewd); end
      n_tests++; if (bus.stall_fetch !== (pf && g != 1)) begin n_fail++; $display("FAIL rnd_stall c%0d got %b want %b", c, bus.stall_fetch, pf && g != 1); end
      own = g == 1 ? 1 : (g == 2 && !dw) ? 2 : g == 3 ? 3 : 0;
      rd = ref_mem[ea];
      if (ewe) ref_mem[da] = dd;
      w = (!pf || g == 1) ? 0 : (w < 15 ? w + 1 : 15);
      lk = g == 1 && fl && !lk;
      if (g == 1) pf = 0;
      if (g == 2) pd = 0;
      if (g == 3) pv = 0;
      tick();
    end
    clear();
  endtask
  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 11);
    test_reset();
    test_priority();
    test_lock();
    test_lock_abandon();
    test_lock_vector();
    test_starvation();
    test_write();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
